// File: rtl/id_issue_scoreboard_pkg.sv
// Shared types and constants for the decode/issue scoreboard slice.
package id_issue_scoreboard_pkg;

    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int DATA_W    = 16;
    localparam int INSTR_W   = 16;

    // Everything the output register hands to EX.
    typedef struct packed {
        logic [INSTR_W-1:0]   instr;
        logic [DATA_W-1:0]    rs1Data;
        logic [DATA_W-1:0]    rs2Data;
        logic [REG_SEL_W-1:0] wrSel;
        logic                 wrEn;
    } issue_t;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [REG_SEL_W-1:0] sel);
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One register's pending-write counter: +issue, -retire, -flush kill, saturating at zero.
module sb_counter #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             ret,
    input  logic             kill,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] eff,
    output logic             err
);

    localparam logic [CNT_W+1:0] MAX_V = (CNT_W+2)'(MAX_INFLIGHT);

    logic signed [CNT_W+1:0] nxt;
    logic        [CNT_W-1:0] cnt_d;

    always_comb begin
        nxt   = signed'({2'b00, cnt})
              + signed'({{(CNT_W+1){1'b0}}, inc})
              - signed'({{(CNT_W+1){1'b0}}, ret})
              - signed'({{(CNT_W+1){1'b0}}, kill});
        cnt_d = nxt[CNT_W+1] ? '0 : nxt[CNT_W-1:0];
        // A retire against an empty counter is an error, so treat it as already clear.
        eff   = (ret && cnt != '0) ? cnt - CNT_W'(1) : cnt;
        err   = (ret && cnt == '0)
              || ({2'b00, cnt} > MAX_V)
              || (!nxt[CNT_W+1] && unsigned'(nxt) > MAX_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_d;
    end

endmodule

// File: rtl/id_issue_scoreboard.sv
// Decode/issue stage: RAW scoreboard, writeback bypass and valid/ready output register to EX.
module id_issue_scoreboard
    import id_issue_scoreboard_pkg::*;
#(
    parameter int WIDTH        = DATA_W,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [REG_SEL_W-1:0] in_rs1Sel,
    input  logic [REG_SEL_W-1:0] in_rs2Sel,
    input  logic                 in_rs1Used,
    input  logic                 in_rs2Used,
    input  logic [REG_SEL_W-1:0] in_wrSel,
    input  logic                 in_wrEn,
    output logic [REG_SEL_W-1:0] read1RegSel,
    output logic [REG_SEL_W-1:0] read2RegSel,
    input  logic [WIDTH-1:0]     read1Data,
    input  logic [WIDTH-1:0]     read2Data,
    input  logic                 wb_en,
    input  logic [REG_SEL_W-1:0] wb_sel,
    input  logic [WIDTH-1:0]     wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [WIDTH-1:0]     out_rs1Data,
    output logic [WIDTH-1:0]     out_rs2Data,
    output logic [REG_SEL_W-1:0] out_wrSel,
    output logic                 out_wrEn,
    output logic                 stall,
    output logic                 err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NUM_REGS-1:0]            ret, inc, kill, cnt_err;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt, eff;
    logic                           src1_hz, src2_hz, cap_stall, slot_free, issue;
    logic                           byp1, byp2;
    issue_t                         out_q, issue_d;
    logic                           err_q;

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (inc[r]),
                .ret  (ret[r]),
                .kill (kill[r]),
                .cnt  (cnt[r]),
                .eff  (eff[r]),
                .err  (cnt_err[r])
            );
        end
    endgenerate

    assign read1RegSel = in_rs1Sel;
    assign read2RegSel = in_rs2Sel;

    always_comb begin
        ret       = sel_onehot(wb_sel) & {NUM_REGS{wb_en}};
        src1_hz   = in_rs1Used && (eff[in_rs1Sel] != '0);
        src2_hz   = in_rs2Used && (eff[in_rs2Sel] != '0);
        cap_stall = in_wrEn && (eff[in_wrSel] == MAX_CNT);
        slot_free = !out_valid || out_ready || flush;
        in_ready  = slot_free && !src1_hz && !src2_hz && !cap_stall;
        issue     = in_valid && in_ready;
        stall     = in_valid && !in_ready;
        inc       = sel_onehot(in_wrSel) & {NUM_REGS{issue && in_wrEn}};
        kill      = sel_onehot(out_q.wrSel) & {NUM_REGS{flush && out_valid && out_q.wrEn}};
        // The regfile write lands at this edge, so the last pending writer must come from the wb bus.
        byp1      = ret[in_rs1Sel] && (cnt[in_rs1Sel] == ONE);
        byp2      = ret[in_rs2Sel] && (cnt[in_rs2Sel] == ONE);
        issue_d.instr   = in_instr;
        issue_d.rs1Data = byp1 ? wb_data : read1Data;
        issue_d.rs2Data = byp2 ? wb_data : read2Data;
        issue_d.wrSel   = in_wrSel;
        issue_d.wrEn    = in_wrEn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_q     <= issue_d;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           err_q <= 1'b0;
        else if (|cnt_err) err_q <= 1'b1;
    end

    assign out_instr   = out_q.instr;
    assign out_rs1Data = out_q.rs1Data;
    assign out_rs2Data = out_q.rs2Data;
    assign out_wrSel   = out_q.wrSel;
    assign out_wrEn    = out_q.wrEn;
    assign err         = err_q;

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed scenarios plus a randomized run checked against a pending-write reference model.
module tb_id_issue_scoreboard;
    import id_issue_scoreboard_pkg::*;

    logic        clk = 1'b0, rst;
    logic        in_valid, in_ready, in_rs1Used, in_rs2Used, in_wrEn;
    logic [15:0] in_instr;
    logic [2:0]  in_rs1Sel, in_rs2Sel, in_wrSel, read1RegSel, read2RegSel, wb_sel, out_wrSel;
    logic [15:0] read1Data, read2Data, wb_data, out_rs1Data, out_rs2Data, out_instr;
    logic        wb_en, flush, out_valid, out_ready, out_wrEn, stall, err;
    logic [15:0] rf [8];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        read1Data = rf[read1RegSel];
        read2Data = rf[read2RegSel];
    end
    always_ff @(posedge clk) if (wb_en) rf[wb_sel] <= wb_data;

    id_issue_scoreboard dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1Sel(in_rs1Sel), .in_rs2Sel(in_rs2Sel), .in_rs1Used(in_rs1Used), .in_rs2Used(in_rs2Used),
        .in_wrSel(in_wrSel), .in_wrEn(in_wrEn), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(read1Data), .read2Data(read2Data), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs1Data(out_rs1Data), .out_rs2Data(out_rs2Data), .out_wrSel(out_wrSel), .out_wrEn(out_wrEn),
        .stall(stall), .err(err)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 0; in_instr = 0; in_rs1Sel = 0; in_rs2Sel = 0; in_rs1Used = 0; in_rs2Used = 0;
        in_wrSel = 0; in_wrEn = 0; wb_en = 0; wb_sel = 0; wb_data = 0; flush = 0; out_ready = 0;
    endtask

    task automatic drv(input logic v, input logic [2:0] r1, input logic u1, input logic [2:0] r2,
                       input logic u2, input logic [2:0] wr, input logic we, input logic [15:0] ins);
        in_valid = v; in_rs1Sel = r1; in_rs1Used = u1; in_rs2Sel = r2; in_rs2Used = u2;
        in_wrSel = wr; in_wrEn = we; in_instr = ins;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        // Preload register file i -> 0x0011*i while the DUT is held in reset.
        for (int i = 0; i < 8; i++) begin
            wb_en = 1; wb_sel = 3'(i); wb_data = 16'(16'h0011 * i); tick();
        end
        wb_en = 0; #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_tests++; if ({out_instr, out_rs1Data, out_rs2Data, out_wrSel, out_wrEn} !== 52'h0) begin
            n_fail++; $display("FAIL reset_fields got %h/%h/%h/%h/%b exp 0", out_instr, out_rs1Data, out_rs2Data, out_wrSel, out_wrEn); end
        tick(); rst = 0;
    endtask

    task automatic test_independent();
        do_reset();
        drv(1, 3'd1, 1, 3'd2, 1, 3'd0, 0, 16'h1200); #1;
        n_tests++; if (in_ready !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL indep_ready got %b/%b exp 1/0", in_ready, stall); end
        n_tests++; if (read1RegSel !== 3'd1 || read2RegSel !== 3'd2) begin n_fail++; $display("FAIL indep_sel got %0d/%0d exp 1/2", read1RegSel, read2RegSel); end
        tick(); in_valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_rs1Data !== 16'h0011 || out_rs2Data !== 16'h0022 || out_instr !== 16'h1200) begin
            n_fail++; $display("FAIL indep_data got %b %h %h %h exp 1 0011 0022 1200", out_valid, out_rs1Data, out_rs2Data, out_instr); end
        out_ready = 1; tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL indep_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_raw();
        do_reset(); out_ready = 1;
        drv(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 16'hA003); #1; tick();
        drv(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 16'hB300);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (stall !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d] got %b/%b exp 1/0", k, stall, in_ready); end
            tick();
        end
        wb_en = 1; wb_sel = 3'd3; wb_data = 16'hBEEF; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b exp 1", in_ready); end
        tick(); wb_en = 0; in_valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_rs1Data !== 16'hBEEF || out_instr !== 16'hB300) begin
            n_fail++; $display("FAIL raw_bypass got %b %h %h exp 1 beef b300", out_valid, out_rs1Data, out_instr); end
    endtask

    task automatic test_capacity();
        do_reset(); out_ready = 1;
        drv(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 16'hC005);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_accept[%0d] got %b exp 1", k, in_ready); end
            tick();
        end
        #1;
        n_tests++; if (in_ready !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL cap_full got %b/%b exp 0/1", in_ready, stall); end
        tick();
        wb_en = 1; wb_sel = 3'd5; wb_data = 16'h5555; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_retire got %b exp 1", in_ready); end
        tick(); in_valid = 0;
        repeat (3) tick();
        wb_en = 0;
        drv(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 16'hC500); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_drained got %b exp 1", in_ready); end
        tick(); in_valid = 0;
        n_tests++; if (out_rs1Data !== 16'h5555) begin n_fail++; $display("FAIL cap_data got %h exp 5555", out_rs1Data); end
    endtask

    task automatic test_flush();
        do_reset(); out_ready = 0;
        drv(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 16'hD006); #1; tick();
        drv(1, 3'd1, 1, 3'd0, 0, 3'd0, 0, 16'hE100); #1;
        n_tests++; if (in_ready !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL flush_backpressure got %b/%b exp 0/1", in_ready, stall); end
        flush = 1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        tick(); flush = 0; in_valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_instr !== 16'hE100 || out_rs1Data !== 16'h0011 || out_wrEn !== 1'b0) begin
            n_fail++; $display("FAIL flush_load got %b %h %h %b exp 1 e100 0011 0", out_valid, out_instr, out_rs1Data, out_wrEn); end
        out_ready = 1; tick();
        drv(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 16'hE600); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_killcnt got %b exp 1", in_ready); end
        in_valid = 0;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err_pre got %b exp 0", err); end
        wb_en = 1; wb_sel = 3'd6; wb_data = 16'h6666; tick(); wb_en = 0;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_err got %b exp 1", err); end
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_issue_retire();
        do_reset(); out_ready = 1;
        drv(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 16'hF002); #1; tick();
        in_valid = 0; tick();
        drv(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 16'hF102);
        wb_en = 1; wb_sel = 3'd2; wb_data = 16'h1111; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ir_issue got %b exp 1", in_ready); end
        tick(); wb_en = 0;
        drv(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 16'hF200); #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ir_net0_stall got %b exp 0", in_ready); end
        tick();
        wb_en = 1; wb_sel = 3'd2; wb_data = 16'h1234; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ir_release got %b exp 1", in_ready); end
        tick(); wb_en = 0; in_valid = 0;
        n_tests++; if (out_rs1Data !== 16'h1234 || out_instr !== 16'hF200) begin n_fail++; $display("FAIL ir_data got %h %h exp 1234 f200", out_rs1Data, out_instr); end
    endtask

    task automatic test_reset_mid();
        do_reset(); out_ready = 0;
        drv(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 16'hA103); #1; tick();
        out_ready = 1; drv(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 16'hA203); #1; tick();
        in_valid = 0; out_ready = 0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %b exp 1", out_valid); end
        #2; rst = 1; #1;
        n_tests++; if (out_valid !== 1'b0 || err !== 1'b0 || out_instr !== 16'h0) begin
            n_fail++; $display("FAIL rmid_async got %b %b %h exp 0 0 0000", out_valid, err, out_instr); end
        rst = 0;
        drv(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 16'hA333); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cnt_clear got %b exp 1", in_ready); end
        tick(); in_valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_instr !== 16'hA333) begin n_fail++; $display("FAIL rmid_accept got %b %h exp 1 a333", out_valid, out_instr); end
    endtask

    task automatic test_random();
        int          pend [8];
        int          exq [$];
        bit          mv, m_u1, m_u2, m_we, exp_rdy, iss;
        logic [15:0] m_ins, m_d1, m_d2;
        logic [2:0]  m_wr;
        int          ret_r, idx;
        do_reset();
        for (int i = 0; i < 8; i++) pend[i] = 0;
        mv = 0; m_u1 = 0; m_u2 = 0; m_we = 0; m_ins = 0; m_d1 = 0; m_d2 = 0; m_wr = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drv(($urandom % 4) != 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                3'($urandom), 1'($urandom), 16'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 8) == 0;
            wb_en = 0; idx = -1;
            if (exq.size() > 0 && ($urandom % 2) == 1) begin
                idx = int'($urandom % exq.size());
                wb_en = 1; wb_sel = 3'(exq[idx]); wb_data = 16'($urandom);
            end
            #1;
            // Hazard rules expressed on outstanding-writer counts.
            exp_rdy = (!mv || out_ready || flush);
            for (int s = 0; s < 3; s++) begin
                int reg_n, left;
                bit used;
                reg_n = (s == 0) ? int'(in_rs1Sel) : (s == 1) ? int'(in_rs2Sel) : int'(in_wrSel);
                used  = (s == 0) ? in_rs1Used : (s == 1) ? in_rs2Used : in_wrEn;
                ret_r = (wb_en && int'(wb_sel) == reg_n) ? 1 : 0;
                left  = pend[reg_n] - ret_r;
                if (used && s < 2 && left != 0) exp_rdy = 0;
                if (used && s == 2 && left == 3) exp_rdy = 0;
            end
            n_tests++; if (in_ready !== exp_rdy || stall !== (in_valid & ~exp_rdy)) begin
                n_fail++; $display("FAIL rand_ready cyc %0d got %b/%b exp %b/%b", cyc, in_ready, stall, exp_rdy, in_valid & ~exp_rdy); end
            iss = in_valid && exp_rdy;
            if (mv && m_we && flush) pend[m_wr]--;
            else if (mv && m_we && out_ready) exq.push_back(int'(m_wr));
            if (idx >= 0) begin pend[wb_sel]--; exq.delete(idx); end
            if (iss) begin
                // A hazard-free operand equals the register's value once this cycle's writeback lands.
                m_d1 = (wb_en && wb_sel == in_rs1Sel) ? wb_data : rf[in_rs1Sel];
                m_d2 = (wb_en && wb_sel == in_rs2Sel) ? wb_data : rf[in_rs2Sel];
                m_u1 = in_rs1Used; m_u2 = in_rs2Used; m_ins = in_instr; m_wr = in_wrSel; m_we = in_wrEn;
                if (in_wrEn) pend[in_wrSel]++;
                mv = 1;
            end else if (flush || out_ready) mv = 0;
            tick();
            n_tests++; if (out_valid !== mv) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, out_valid, mv); end
            if (mv) begin
                n_tests++; if (out_instr !== m_ins || out_wrEn !== m_we || (m_we && out_wrSel !== m_wr)
                               || (m_u1 && out_rs1Data !== m_d1) || (m_u2 && out_rs2Data !== m_d2)) begin
                    n_fail++; $display("FAIL rand_fields cyc %0d got %h %b %0d %h %h exp %h %b %0d %h %h", cyc,
                        out_instr, out_wrEn, out_wrSel, out_rs1Data, out_rs2Data, m_ins, m_we, m_wr, m_d1, m_d2); end
            end
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err got %b exp 0", err); end
        idle();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_capacity();
        test_flush();
        test_issue_retire();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
